// File: rtl/pipeline_stage.sv
// rtl/pipeline_stage.sv - valid/ready register slice; optional one-entry skid buffer under PIPELINE_STAGE_SKID_EN
module pipeline_stage #(
  parameter int DATA_W = 32,
  parameter int NDATA  = 2,
  parameter int CTRL_W = 2,
  parameter int RD_W   = 5
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CTRL_W-1:0]       in_ctrl,
  input  logic [DATA_W*NDATA-1:0] in_data,
  input  logic [RD_W-1:0]         in_rd,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CTRL_W-1:0]       out_ctrl,
  output logic [DATA_W*NDATA-1:0] out_data,
  output logic [RD_W-1:0]         out_rd,
  output logic [1:0]              occupancy
);
  localparam int PW = DATA_W * NDATA;

  logic              outValid, outValidNext;
  logic [CTRL_W-1:0] outCtrlQ, outCtrlNext;
  logic [PW-1:0]     outDataQ, outDataNext;
  logic [RD_W-1:0]   outRdQ, outRdNext;
  logic              accept, deliver;

  // A flushed cycle never accepts, whatever in_ready says.
  assign accept    = in_valid && in_ready && !flush;
  assign deliver   = outValid && out_ready;
  assign out_valid = outValid;
  assign out_ctrl  = outValid ? outCtrlQ : '0;
  assign out_data  = outDataQ;
  assign out_rd    = outRdQ;

`ifdef PIPELINE_STAGE_SKID_EN
  logic              skidValid, skidValidNext;
  logic [CTRL_W-1:0] skidCtrlQ, skidCtrlNext;
  logic [PW-1:0]     skidDataQ, skidDataNext;
  logic [RD_W-1:0]   skidRdQ, skidRdNext;
  logic              inReadyQ;

  assign in_ready  = inReadyQ;
  assign occupancy = {1'b0, outValid} + {1'b0, skidValid};

  always_comb begin
    outValidNext  = outValid;
    outCtrlNext   = outCtrlQ;
    outDataNext   = outDataQ;
    outRdNext     = outRdQ;
    skidValidNext = skidValid;
    skidCtrlNext  = skidCtrlQ;
    skidDataNext  = skidDataQ;
    skidRdNext    = skidRdQ;
    if (flush) begin
      outValidNext  = 1'b0;
      skidValidNext = 1'b0;
    end else if (skidValid) begin
      // Full: in_ready is low, so only a deliver can move things.
      if (deliver) begin
        outCtrlNext   = skidCtrlQ;
        outDataNext   = skidDataQ;
        outRdNext     = skidRdQ;
        skidValidNext = 1'b0;
      end
    end else if (accept && (!outValid || deliver)) begin
      outValidNext = 1'b1;
      outCtrlNext  = in_ctrl;
      outDataNext  = in_data;
      outRdNext    = in_rd;
    end else if (accept) begin
      skidValidNext = 1'b1;
      skidCtrlNext  = in_ctrl;
      skidDataNext  = in_data;
      skidRdNext    = in_rd;
    end else if (deliver) begin
      outValidNext = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      skidValid <= 1'b0;
      skidCtrlQ <= '0;
      skidDataQ <= '0;
      skidRdQ   <= '0;
      inReadyQ  <= 1'b1;
    end else begin
      skidValid <= skidValidNext;
      skidCtrlQ <= skidCtrlNext;
      skidDataQ <= skidDataNext;
      skidRdQ   <= skidRdNext;
      inReadyQ  <= !(outValidNext && skidValidNext);
    end
  end
`else
  assign in_ready  = !outValid || out_ready;
  assign occupancy = {1'b0, outValid};

  always_comb begin
    outValidNext = outValid;
    outCtrlNext  = outCtrlQ;
    outDataNext  = outDataQ;
    outRdNext    = outRdQ;
    if (flush) begin
      outValidNext = 1'b0;
    end else if (accept) begin
      outValidNext = 1'b1;
      outCtrlNext  = in_ctrl;
      outDataNext  = in_data;
      outRdNext    = in_rd;
    end else if (deliver) begin
      outValidNext = 1'b0;
    end
  end
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      outValid <= 1'b0;
      outCtrlQ <= '0;
      outDataQ <= '0;
      outRdQ   <= '0;
    end else begin
      outValid <= outValidNext;
      outCtrlQ <= outCtrlNext;
      outDataQ <= outDataNext;
      outRdQ   <= outRdNext;
    end
  end
endmodule

// File: tb/tb_pipeline_stage.sv
// tb/tb_pipeline_stage.sv - scoreboard bench for pipeline_stage (either PIPELINE_STAGE_SKID_EN build)
module tb_pipeline_stage;
  localparam int DATA_W = 32;
  localparam int NDATA  = 2;
  localparam int CTRL_W = 2;
  localparam int RD_W   = 5;
  localparam int PW     = DATA_W * NDATA;
`ifdef PIPELINE_STAGE_SKID_EN
  localparam int CAP = 2;
`else
  localparam int CAP = 1;
`endif

  typedef struct packed {
    logic [CTRL_W-1:0] c;
    logic [PW-1:0]     d;
    logic [RD_W-1:0]   r;
  } ent_t;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              in_valid = 1'b0, in_ready;
  logic [CTRL_W-1:0] in_ctrl = '0;
  logic [PW-1:0]     in_data = '0;
  logic [RD_W-1:0]   in_rd = '0;
  logic              flush = 1'b0;
  logic              out_valid, out_ready = 1'b0;
  logic [CTRL_W-1:0] out_ctrl;
  logic [PW-1:0]     out_data;
  logic [RD_W-1:0]   out_rd;
  logic [1:0]        occupancy;

  pipeline_stage #(.DATA_W(DATA_W), .NDATA(NDATA), .CTRL_W(CTRL_W), .RD_W(RD_W)) dut (
    .CLK(CLK), .RESET(RESET), .in_valid(in_valid), .in_ready(in_ready), .in_ctrl(in_ctrl),
    .in_data(in_data), .in_rd(in_rd), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .out_rd(out_rd), .occupancy(occupancy)
  );

  always #5 CLK = ~CLK;

  ent_t            sbq[$];
  int              nTests = 0;
  int              nFail = 0;
  logic            modelReady = 1'b1;
  logic [PW-1:0]   lastData = '0;
  logic [RD_W-1:0] lastRd = '0;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: the stage must always look like an in-order queue of what was accepted.
  always begin
    int   sz;
    logic expReady;
    @(negedge CLK);
    #1;
    sz = sbq.size();
    expReady = (CAP == 2) ? (sz < 2) : (sz == 0 || out_ready);
    chk("occupancy", 128'(occupancy), 128'(sz));
    chk("out_valid", 128'(out_valid), 128'(sz > 0));
    chk("in_ready", 128'(in_ready), 128'(expReady));
    if (sz > 0) begin
      chk("out_ctrl", 128'(out_ctrl), 128'(sbq[0].c));
      chk("out_data", 128'(out_data), 128'(sbq[0].d));
      chk("out_rd", 128'(out_rd), 128'(sbq[0].r));
      lastData = sbq[0].d;
      lastRd   = sbq[0].r;
    end else begin
      chk("bubble_ctrl", 128'(out_ctrl), 128'(0));
      chk("hold_data", 128'(out_data), 128'(lastData));
      chk("hold_rd", 128'(out_rd), 128'(lastRd));
    end
    modelReady = expReady;
    if (RESET) begin
      sbq.delete();
      lastData = '0;
      lastRd   = '0;
    end else if (flush) begin
      sbq.delete();
    end else if (sz > 0 && out_ready) begin
      void'(sbq.pop_front());
    end
  end

  // Driver: set inputs for one cycle; record the entry in the scoreboard if the model accepts it.
  task automatic cyc(input logic iv, input logic [CTRL_W-1:0] c, input logic [PW-1:0] d,
                     input logic [RD_W-1:0] r, input logic ordy, input logic fl, input logic rst);
    ent_t e;
    @(negedge CLK);
    in_valid = iv; in_ctrl = c; in_data = d; in_rd = r;
    out_ready = ordy; flush = fl; RESET = rst;
    #2;
    if (!rst && !fl && iv && modelReady) begin
      e.c = c; e.d = d; e.r = r;
      sbq.push_back(e);
    end
  endtask

  function automatic logic [PW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // streaming words 1..8
    for (int k = 1; k <= 8; k++) cyc(1, CTRL_W'(k), PW'(k), RD_W'(k), 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // stall with input pressure, then release
    for (int k = 0; k < 3; k++) cyc(1, 2'b01, rnd_data(), RD_W'(k), 0, 0, 0);
    for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 1, 0, 0);
    // bubble ctrl
    cyc(1, 2'b11, rnd_data(), 5'd7, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // flush with entries held and a new input offered
    cyc(1, 2'b10, rnd_data(), 5'd1, 0, 0, 0);
    cyc(1, 2'b10, rnd_data(), 5'd2, 0, 0, 0);
    cyc(1, 2'b11, rnd_data(), 5'd3, 0, 1, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // reset mid-stall
    for (int k = 0; k < 3; k++) cyc(1, 2'b11, rnd_data(), RD_W'(k), 0, 0, 0);
    cyc(1, 2'b11, rnd_data(), 5'd9, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 1, 0, 0);
    // randomized traffic
    for (int k = 0; k < 500; k++)
      cyc($urandom_range(0, 9) < 7, CTRL_W'($urandom()), rnd_data(), RD_W'($urandom()),
          $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3, $urandom_range(0, 199) < 2);
    for (int k = 0; k < 4; k++) cyc(0, 0, 0, 0, 1, 0, 0);
    @(negedge CLK);
    #3;
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
